regfile_wb_buffer: RTL
======================

// Module: regfile_wb_buffer
// PURPOSE
//  Write-back buffer that drives the regfile write port (we/wa/wd) on behalf of the pipeline.
//  - Accepts write-back requests over a valid/ready handshake.
//  - Queues them in order and retires one per cycle into the regfile.
//  - Sits between the execute/memory stages and regfile; also fronts the regfile read data toward decode.
// PARAMETERS
//  DATA_W  32  register data width
//  ADDR_W  5   register address width (2**ADDR_W registers, r0 hardwired to zero)
//  DEPTH   4   pending-write queue entries; power of two, >=2
// PORTS
//  clk       in   1       clock, all state on rising edge
//  rst       in   1       synchronous, active-high reset
//  wb_valid  in   1       write-back request valid
//  wb_ready  out  1       buffer can accept request (= count < DEPTH)
//  wb_addr   in   ADDR_W  destination register
//  wb_data   in   DATA_W  write data
//  hold      in   1       pause draining (regfile port borrowed elsewhere)
//  flush     in   1       discard all queued, not-yet-retired writes
//  we        out  1       regfile write enable (registered)
//  wa        out  ADDR_W  regfile write address (registered)
//  wd        out  DATA_W  regfile write data (registered)
//  ra1, ra2  in   ADDR_W  decode read addresses (also driven to regfile)
//  rd1, rd2  in   DATA_W  regfile read data
//  op_a,op_b out  DATA_W  operands to decode
//  empty     out  1       queue empty and we==0
// BEHAVIOUR
//  - Reset: queue cleared, count=0, state=IDLE, we=0, wa=0, wd=0, empty=1. wb_ready=1 in the first cycle after reset.
//  - Accept: wb_valid & wb_ready at edge N enqueues {addr,data}.
//    - wb_addr==0 is accepted but not enqueued (no write, no count change).
//  - Retire: in DRAIN with count>0 and !hold, the head pops. we=1, wa/wd=head in cycle N+1.
//    - Min latency accept->we is 2 edges (enqueue, then pop).
//    - we=0 in any cycle with no pop.
//  - Full: wb_ready=0 when count==DEPTH, even if a pop occurs in the same cycle (no combinational ready path).
//  - Simultaneous push+pop: count unchanged, order preserved. Pointers wrap modulo DEPTH.
//  - FSM:
//    - IDLE -> DRAIN on count>0 or push.
//    - DRAIN -> HOLD on hold.
//    - HOLD -> DRAIN on !hold.
//    - DRAIN -> IDLE when count becomes 0.
//    - Any state -> IDLE on flush.
//  - flush (priority over push/pop): queue cleared next edge, we=0 next cycle.
//    - A push in the flush cycle is dropped.
//    - A write already on we/wa/wd completes.
//  - rst mid-operation: all pending writes lost, outputs return to reset values next edge.
// CONFIGURATION
//  - Macro WB_FWD_EN defined: op_a/op_b forward pending data.
//    - Sources: youngest matching queue entry, else the current we/wa/wd, else rd1/rd2.
//    - Read address 0 always yields 0.
//    - Purely combinational from state; no extra latency.
//  - Not defined: op_a=rd1, op_b=rd2 unmodified.
//    - Decode must stall until empty=1 before reading a register it depends on.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - REG_ADDR_W, REG_DATA_W
//    - typedef wb_entry_t {addr,data}
//    - enum wb_state_e {IDLE,DRAIN,HOLD}
//  - One sub-module: wb_fifo (circular buffer, head/tail/count, push/pop/flush).
//  - Forward-match mux lives in this module.
// TESTING
//  1 Reset: rst=1 two cycles -> we=0, wa=0, wd=0, empty=1, wb_ready=1.
//  2 Push {2,10} -> we=1, wa=2, wd=10 two edges later; empty=1 the cycle after.
//  3 hold=1, push 4 writes -> wb_ready=0 after 4th. Fifth push not accepted.
//    Release hold -> 4 writes retire in order, one per cycle.
//  4 Push {0,25} -> no we pulse, count stays 0. With WB_FWD_EN, ra1=0 -> op_a=0.
//  5 WB_FWD_EN, hold=1, push {1,50},{1,60}; ra2=1, rd2=7 -> op_b=60.
//    Without the macro -> op_b=7.
//  6 3 entries queued, flush=1 with simultaneous push -> count=0, we=0 next cycle, pushed entry absent.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types: register-file widths, pending write-back entry and the
// write-back buffer drain states.
package cpu_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {IDLE, DRAIN, HOLD} wb_state_e;
endpackage

// File: rtl/regfile_wb_buffer_if.sv
// Write-back request channel: valid/ready handshake carrying a register address and data.
interface regfile_wb_buffer_if
   import cpu_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
);
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;

   modport master (output wb_valid, wb_addr, wb_data, input wb_ready);
   modport slave  (input wb_valid, wb_addr, wb_data, output wb_ready);
endinterface

// File: rtl/regfile_wb_buffer_fifo.sv
// wb_fifo: circular pending-write queue with head/tail pointers and occupancy count.
// rst or flush empties it on the next edge; payload storage is never cleared.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = PW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  wb_entry_t             din,
   output wb_entry_t [DEPTH-1:0] entries,
   output logic [PW-1:0]         headPtr,
   output logic [CW-1:0]         count
);
   logic [PW-1:0] tailPtr;

   // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         headPtr <= '0;
         tailPtr <= '0;
         count   <= '0;
      end else begin
         if (push) tailPtr <= tailPtr + 1'b1;
         if (pop)  headPtr <= headPtr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) entries[tailPtr] <= din;
   end
endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: queues write-backs and retires one per cycle onto the regfile write port.
// Optional macro WB_FWD_EN forwards pending write data onto op_a/op_b.
module regfile_wb_buffer
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DEPTH  = 4
) (
   input  logic               clk,
   input  logic               rst,
   regfile_wb_buffer_if.slave wb,
   input  logic               hold,
   input  logic               flush,
   output logic               we,
   output logic [ADDR_W-1:0]  wa,
   output logic [DATA_W-1:0]  wd,
   input  logic [ADDR_W-1:0]  ra1,
   input  logic [ADDR_W-1:0]  ra2,
   input  logic [DATA_W-1:0]  rd1,
   input  logic [DATA_W-1:0]  rd2,
   output logic [DATA_W-1:0]  op_a,
   output logic [DATA_W-1:0]  op_b,
   output logic               empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] entries;
   wb_entry_t             head;
   logic [PW-1:0]         headPtr;
   logic [CW-1:0]         count, countNxt;
   logic                  push, pop;
   wb_state_e             state, stateNxt;

   // Ready depends only on registered occupancy; a same-cycle pop never frees a slot early.
   assign wb.wb_ready = (count != CW'(DEPTH));
   // Writes to r0 complete the handshake but are discarded.
   assign push = wb.wb_valid && wb.wb_ready && (wb.wb_addr != '0) && !flush;
   assign pop  = (state == DRAIN) && (count != '0) && !hold && !flush;
   assign head = entries[headPtr];
   assign countNxt = count + CW'(push) - CW'(pop);

   wb_fifo #(.DEPTH(DEPTH)) uFifo (
      .clk, .rst, .push, .pop, .flush,
      .din('{addr: wb.wb_addr, data: wb.wb_data}),
      .entries, .headPtr, .count
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      if (flush) stateNxt = IDLE;
      else begin
         case (state)
            IDLE:    if (count != '0 || push) stateNxt = DRAIN;
            DRAIN:   if (hold) stateNxt = HOLD;
                     else if (countNxt == '0) stateNxt = IDLE;
            HOLD:    if (!hold) stateNxt = DRAIN;
            default: stateNxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we <= 1'b0;
         wa <= '0;
         wd <= '0;
      end else begin
         we <= pop;
         if (pop) begin
            wa <= head.addr;
            wd <= head.data;
         end
      end
   end

   assign empty = (count == '0) && !we;

`ifdef WB_FWD_EN
   function automatic logic [DATA_W-1:0] fwdRead(input logic [ADDR_W-1:0] ra,
                                                  input logic [DATA_W-1:0] rd);
      logic [DATA_W-1:0] v;
      logic [PW-1:0]     idx;
      v = (we && wa == ra) ? wd : rd;
      // Walk oldest to youngest so the youngest matching entry wins.
      for (int k = 0; k < DEPTH; k++) begin
         idx = headPtr + PW'(k);
         if (CW'(k) < count && entries[idx].addr == ra) v = entries[idx].data;
      end
      return (ra == '0) ? '0 : v;
   endfunction

   assign op_a = fwdRead(ra1, rd1);
   assign op_b = fwdRead(ra2, rd2);
`else
   assign op_a = rd1;
   assign op_b = rd2;
   // Read addresses only feed the regfile directly in this build.
   logic unusedRa;
   assign unusedRa = ^{ra1, ra2};
`endif
endmodule
